// File: rtl/lpf_sequencer.sv
// Sequencer for the moving-average LPF: registers ADC samples, issues shift enables and
// clears, tracks window fill, flags full-window means, decimates them and watches for lost samples.
module lpf_sequencer #(
    parameter int NBIT      = 32,
    parameter int DEPTH     = 32,
    parameter int DEC       = 8,
    parameter int TIMEOUT   = 1000,
    parameter int FLUSH_CYC = 2,
    localparam int FW = $clog2(DEPTH + 1),
    localparam int DW = $clog2(DEC + 1),
    localparam int WW = $clog2(TIMEOUT + 1),
    localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1
) (
    input  logic                   i_clock,
    input  logic                   i_RESET,
    input  logic                   i_enable,
    input  logic                   i_sample,
    input  logic                   i_flush,
    input  logic signed [NBIT-1:0] i_data,
    output logic signed [NBIT-1:0] o_data,
    output logic                   o_shift_en,
    output logic                   o_clear,
    output logic                   o_mean_strobe,
    output logic                   o_dec_strobe,
    output logic [FW-1:0]          o_fill_count,
    output logic [1:0]             o_state,
    output logic                   o_stale
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FLUSH = 2'b01,
        FILL  = 2'b10,
        RUN   = 2'b11
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          fcnt_q, fcnt_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic [WW-1:0]          wd_q, wd_d;
    logic signed [NBIT-1:0] data_q, data_d;
    logic                   shift_q, shift_d;
    logic                   clear_q, clear_d;
    logic                   mean_q, mean_d;
    logic                   dec_q, dec_d;
    logic                   stale_q, stale_d;

    logic active, accept, timeout;

    always_comb begin
        active  = (state_q == FILL) || (state_q == RUN);
        accept  = active && i_enable && i_sample && !i_flush;
        timeout = active && !accept && (wd_q == WW'(TIMEOUT - 1));

        state_d = state_q;
        fcnt_d  = fcnt_q;
        fill_d  = fill_q;
        dcnt_d  = dcnt_q;
        wd_d    = wd_q;
        data_d  = data_q;
        stale_d = stale_q;
        shift_d = 1'b0;
        clear_d = 1'b0;
        mean_d  = 1'b0;
        dec_d   = 1'b0;

        if (!i_enable) begin
            // Dropping enable cancels anything in flight and parks all counters.
            state_d = IDLE;
            fcnt_d  = '0;
            fill_d  = '0;
            dcnt_d  = '0;
            wd_d    = '0;
            stale_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                    clear_d = 1'b1;
                end
                FLUSH: begin
                    clear_d = 1'b1;
                    fill_d  = '0;
                    dcnt_d  = '0;
                    wd_d    = '0;
                    if (i_flush) begin
                        fcnt_d = '0;
                    end else if (fcnt_q == CW'(FLUSH_CYC - 1)) begin
                        state_d = FILL;
                        clear_d = 1'b0;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                default: begin
                    if (i_flush || timeout) begin
                        state_d = FLUSH;
                        clear_d = 1'b1;
                        fcnt_d  = '0;
                        fill_d  = '0;
                        dcnt_d  = '0;
                        wd_d    = '0;
                        stale_d = stale_q | timeout;
                    end else begin
                        // Previous cycle's shift left the window full: LPF output is a fresh mean.
                        if (shift_q && (fill_q == FW'(DEPTH))) begin
                            mean_d = 1'b1;
                            if (dcnt_q == DW'(DEC - 1)) begin
                                dec_d  = 1'b1;
                                dcnt_d = '0;
                            end else begin
                                dcnt_d = dcnt_q + 1'b1;
                            end
                        end
                        if (accept) begin
                            data_d  = i_data;
                            shift_d = 1'b1;
                            wd_d    = '0;
                            stale_d = 1'b0;
                            if (fill_q != FW'(DEPTH))
                                fill_d = fill_q + 1'b1;
                        end else begin
                            wd_d = wd_q + 1'b1;
                        end
                        if (fill_d == FW'(DEPTH))
                            state_d = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            fill_q  <= '0;
            dcnt_q  <= '0;
            wd_q    <= '0;
            data_q  <= '0;
            shift_q <= 1'b0;
            clear_q <= 1'b0;
            mean_q  <= 1'b0;
            dec_q   <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            fill_q  <= fill_d;
            dcnt_q  <= dcnt_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
            shift_q <= shift_d;
            clear_q <= clear_d;
            mean_q  <= mean_d;
            dec_q   <= dec_d;
            stale_q <= stale_d;
        end
    end

    assign o_data        = data_q;
    assign o_shift_en    = shift_q;
    assign o_clear       = clear_q;
    assign o_mean_strobe = mean_q;
    assign o_dec_strobe  = dec_q;
    assign o_fill_count  = fill_q;
    assign o_state       = state_q;
    assign o_stale       = stale_q;

endmodule

// File: tb/tb_lpf_sequencer.sv
// Scoreboard bench for lpf_sequencer: stimulus pushes expected shifts/means, a negedge
// monitor pops them whenever the DUT strobes, and a small LPF window model yields the mean.
module tb_lpf_sequencer;

    logic               i_clock;
    logic               i_RESET;
    logic               i_enable;
    logic               i_sample;
    logic               i_flush;
    logic signed [31:0] i_data;
    logic signed [31:0] o_data;
    logic               o_shift_en;
    logic               o_clear;
    logic               o_mean_strobe;
    logic               o_dec_strobe;
    logic [2:0]         o_fill_count;
    logic [1:0]         o_state;
    logic               o_stale;

    lpf_sequencer #(
        .NBIT(32), .DEPTH(4), .DEC(2), .TIMEOUT(16), .FLUSH_CYC(2)
    ) dut (
        .i_clock      (i_clock),
        .i_RESET      (i_RESET),
        .i_enable     (i_enable),
        .i_sample     (i_sample),
        .i_flush      (i_flush),
        .i_data       (i_data),
        .o_data       (o_data),
        .o_shift_en   (o_shift_en),
        .o_clear      (o_clear),
        .o_mean_strobe(o_mean_strobe),
        .o_dec_strobe (o_dec_strobe),
        .o_fill_count (o_fill_count),
        .o_state      (o_state),
        .o_stale      (o_stale)
    );

    typedef struct { int data; int fill; } shift_exp_t;
    typedef struct { int dec; int mean; } mean_exp_t;

    shift_exp_t sq[$];
    mean_exp_t  mq[$];
    int         win[4];
    int         n_chk = 0;
    int         n_fail = 0;

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mean is checked before the same-cycle shift enters the window model.
    always @(negedge i_clock) begin
        if (i_RESET) begin
            if (o_clear)
                for (int k = 0; k < 4; k++) win[k] = 0;
            if (o_mean_strobe) begin
                chk("mean_expected", int'(mq.size() > 0), 1);
                if (mq.size() > 0) begin
                    mean_exp_t e;
                    e = mq.pop_front();
                    chk("dec_strobe", int'(o_dec_strobe), e.dec);
                    chk("lpf_mean", (win[0] + win[1] + win[2] + win[3]) / 4, e.mean);
                end
            end else if (o_dec_strobe) begin
                chk("dec_without_mean", 1, int'(o_mean_strobe));
            end
            if (o_shift_en) begin
                chk("shift_expected", int'(sq.size() > 0), 1);
                if (sq.size() > 0) begin
                    shift_exp_t s;
                    s = sq.pop_front();
                    chk("shift_data", o_data, s.data);
                    chk("shift_fill", int'(o_fill_count), s.fill);
                end
                win[3] = win[2]; win[2] = win[1]; win[1] = win[0]; win[0] = o_data;
            end
        end
    end

    task automatic put(input int d, input int f, input bit has_mean, input int dec, input int m);
        @(negedge i_clock);
        i_sample = 1'b1;
        i_data   = d;
        sq.push_back('{d, f});
        if (has_mean) mq.push_back('{dec, m});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clock);
            i_sample = 1'b0;
            i_flush  = 1'b0;
        end
    endtask

    // Counts o_clear cycles until FILL is reached (bounded).
    task automatic wait_fill(output int nclr);
        nclr = 0;
        for (int k = 0; k < 10 && o_state != 2'b10; k++) begin
            @(negedge i_clock);
            if (o_clear) nclr++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int nclr, nw;
        i_RESET = 1'b0; i_enable = 1'b0; i_sample = 1'b0; i_flush = 1'b0; i_data = 0;
        for (int k = 0; k < 4; k++) win[k] = 0;
        repeat (2) @(negedge i_clock);
        chk("rst_state", int'(o_state), 0);
        chk("rst_clear", int'(o_clear), 0);
        chk("rst_shift", int'(o_shift_en), 0);
        chk("rst_fill", int'(o_fill_count), 0);
        chk("rst_stale", int'(o_stale), 0);
        chk("rst_mean", int'(o_mean_strobe), 0);

        // 1: enable -> FLUSH for two clear cycles -> FILL
        i_RESET = 1'b1;
        @(negedge i_clock);
        i_enable = 1'b1;
        @(negedge i_clock);
        chk("t1_flush_state", int'(o_state), 1);
        nclr = 1;
        for (int k = 0; k < 10 && o_state != 2'b10; k++) begin
            @(negedge i_clock);
            if (o_clear) nclr++;
        end
        chk("t1_clear_cycles", nclr, 2);
        chk("t1_state_fill", int'(o_state), 2);
        chk("t1_fill", int'(o_fill_count), 0);
        chk("t1_shift", int'(o_shift_en), 0);

        // 2: spaced fill, mean of 4,8,12,16 = 10
        put(4, 1, 0, 0, 0);  idle(2);
        put(8, 2, 0, 0, 0);  idle(2);
        put(12, 3, 0, 0, 0); idle(1);
        chk("t2_still_fill", int'(o_state), 2);
        idle(1);
        put(16, 4, 1, 0, 10); idle(1);
        chk("t2_run", int'(o_state), 3);
        idle(2);

        // 3: back-to-back samples, dec on every second mean
        for (int i = 0; i < 8; i++)
            put(20 + 4 * i, 4, 1, (i % 2 == 0) ? 1 : 0, 14 + 4 * i);
        idle(3);

        // 4: flush and sample together -> no shift, clear 2 cycles, FILL with 0
        @(negedge i_clock);
        i_flush = 1'b1; i_sample = 1'b1; i_data = 99;
        idle(1);
        chk("t4_flush_state", int'(o_state), 1);
        chk("t4_shift", int'(o_shift_en), 0);
        wait_fill(nclr);
        chk("t4_clear_cycles", nclr + int'(1), 2);
        chk("t4_fill", int'(o_fill_count), 0);
        chk("t4_state_fill", int'(o_state), 2);

        // 5: refill then starve the watchdog for 16 cycles
        put(1, 1, 0, 0, 0); idle(2);
        put(2, 2, 0, 0, 0); idle(2);
        put(3, 3, 0, 0, 0); idle(2);
        put(4, 4, 1, 0, 2);
        idle(1);
        nw = 0;
        for (int k = 0; k < 40 && !o_stale; k++) begin
            @(negedge i_clock);
            nw++;
        end
        chk("t5_stale_cycles", nw, 16);
        chk("t5_stale", int'(o_stale), 1);
        chk("t5_flush_state", int'(o_state), 1);
        wait_fill(nclr);
        chk("t5_clear_cycles", nclr + int'(1), 2);
        chk("t5_stale_held", int'(o_stale), 1);
        put(5, 1, 0, 0, 0); idle(1);
        chk("t5_stale_cleared", int'(o_stale), 0);
        chk("t5_fill_one", int'(o_fill_count), 1);

        // 6: async reset while a shift is presented and its mean is pending
        put(6, 2, 0, 0, 0); idle(2);
        put(7, 3, 0, 0, 0); idle(2);
        put(8, 4, 1, 0, 6); idle(3);
        @(negedge i_clock);
        i_sample = 1'b1; i_data = 77;
        @(posedge i_clock);
        #1;
        chk("t6_inflight_shift", int'(o_shift_en), 1);
        chk("t6_inflight_data", o_data, 77);
        #1 i_RESET = 1'b0;
        #1;
        chk("t6_rst_shift", int'(o_shift_en), 0);
        chk("t6_rst_state", int'(o_state), 0);
        chk("t6_rst_data", o_data, 0);
        chk("t6_rst_fill", int'(o_fill_count), 0);
        i_sample = 1'b0; i_enable = 1'b0;
        repeat (3) @(negedge i_clock);
        chk("t6_no_late_mean", int'(o_mean_strobe), 0);
        i_RESET = 1'b1;
        repeat (4) @(negedge i_clock);
        chk("t6_idle", int'(o_state), 0);
        chk("t6_no_late_shift", int'(o_shift_en), 0);

        chk("shift_queue_drained", sq.size(), 0);
        chk("mean_queue_drained", mq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
